dvi_timing_gen: RTL and testbench

Video timing and test-pattern generator driving the parallel RGB/sync input of the board's DVI transmitter, whose I2C configuration is handled by the NEORV32 over TWI. It runs in the pixel clock domain, produces standard raster timing (default 640x480@60, 25.175 MHz pixel clock) and fills active video with one of four selectable patterns. All outputs are registered.

---
 rtl/dvi_timing_gen.sv | 199 +++++++++++++++++++
 tb/tb_dvi_timing_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen
// Raster timing and test-pattern generator for the parallel RGB/sync input
// of a DVI transmitter. Runs entirely in the pixel clock domain. Every output
// is registered and lags the internal counters by exactly one cycle.
//
// Ports:
//   clk_i          pixel clock
//   rstn_i         asynchronous active-low reset
//   en_i           run enable; low forces counters to 0 and outputs inactive
//   pattern_i      pattern select (0 bars, 1 grid, 2 gradient, 3 grey),
//                  sampled at the first pixel of each frame
//   hsync_o        horizontal sync (asserted level HS_POL)
//   vsync_o        vertical sync (asserted level VS_POL), line aligned
//   de_o           data enable, high during active video
//   rgb_o          {R,G,B} pixel data, 0 outside active video
//   x_o, y_o       coordinates of the pixel currently on rgb_o
//   frame_start_o  one-cycle pulse on the first active pixel of a frame
module dvi_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_TOT_M1  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_TOT_M1  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_W   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W   = 12'(V_ACTIVE);
  localparam logic [11:0] H_ACT_M1  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_M1  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W_M1  = 12'(H_ACTIVE / 8 - 1);

  // Colour of each of the eight vertical bars, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      3'd7:    c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [11:0] h_cnt_r;
  logic [11:0] v_cnt_r;
  logic [11:0] bar_pix_r;
  logic [2:0]  bar_idx_r;
  logic [1:0]  pattern_r;

  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        active_s;
  logic        hs_act_s;
  logic        vs_act_s;
  logic        origin_s;
  logic [1:0]  pattern_s;
  logic [23:0] rgb_s;

  // Decode counter state into region flags and the pattern in force.
  always_comb begin
    h_wrap_s = (h_cnt_r == H_TOT_M1);
    v_wrap_s = (v_cnt_r == V_TOT_M1);
    active_s = (h_cnt_r < H_ACT_W) && (v_cnt_r < V_ACT_W);
    hs_act_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_act_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    origin_s = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
    // The frame's first pixel already uses the value being latched.
    if (origin_s) begin
      pattern_s = pattern_i;
    end else begin
      pattern_s = pattern_r;
    end
  end

  // Pixel colour for the current counter position.
  always_comb begin
    rgb_s = 24'h000000;
    if (active_s) begin
      case (pattern_s)
        2'd0: rgb_s = bar_colour(bar_idx_r);
        2'd1: begin
          if ((h_cnt_r[4:0] == 5'd0) || (v_cnt_r[4:0] == 5'd0) ||
              (h_cnt_r == H_ACT_M1) || (v_cnt_r == V_ACT_M1)) begin
            rgb_s = 24'hFFFFFF;
          end else begin
            rgb_s = 24'h000000;
          end
        end
        2'd2: rgb_s = {h_cnt_r[7:0], v_cnt_r[7:0], h_cnt_r[7:0] ^ v_cnt_r[7:0]};
        2'd3: rgb_s = 24'h808080;
        default: rgb_s = 24'h000000;
      endcase
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Raster counters; vertical steps when the horizontal counter wraps.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (!en_i) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (h_wrap_s) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= v_wrap_s ? 12'd0 : v_cnt_r + 12'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 12'd1;
    end
  end

  // Bar index tracks h_cnt without a divider: steps every H_ACTIVE/8 pixels.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bar_pix_r <= 12'd0;
      bar_idx_r <= 3'd0;
    end else if (!en_i || h_wrap_s) begin
      bar_pix_r <= 12'd0;
      bar_idx_r <= 3'd0;
    end else if (bar_pix_r == BAR_W_M1) begin
      bar_pix_r <= 12'd0;
      bar_idx_r <= bar_idx_r + 3'd1;
    end else begin
      bar_pix_r <= bar_pix_r + 12'd1;
    end
  end

  // Pattern select is only sampled at the frame origin.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pattern_r <= 2'd0;
    end else if (en_i && origin_s) begin
      pattern_r <= pattern_i;
    end
  end

  // Output registers: one cycle behind the counters, all mutually aligned.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      rgb_o         <= 24'h000000;
      x_o           <= 12'd0;
      y_o           <= 12'd0;
      frame_start_o <= 1'b0;
    end else if (!en_i) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      rgb_o         <= 24'h000000;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_o       <= vs_act_s ? VS_POL : ~VS_POL;
      de_o          <= active_s;
      rgb_o         <= rgb_s;
      frame_start_o <= origin_s;
      if (active_s) begin
        x_o <= h_cnt_r;
        y_o <= v_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Self-checking bench for dvi_timing_gen using a reduced raster so that
// several whole frames fit in a short run. A reference model pushes the
// expected output vector at each clock edge; the falling edge pops and
// compares it against the DUT. Directed checks cover the timing plan.
module tb_dvi_timing_gen;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 80
  localparam int VT = VA + VFP + VSW + VBP;   // 47
  localparam int FRAME = HT * VT;             // 3760

  localparam logic [51:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 24'd0};

  bit          clk;
  logic        rstn_i;
  logic        en_i;
  logic [1:0]  pattern_i;
  logic        hsync_o, vsync_o, de_o, frame_start_o;
  logic [23:0] rgb_o;
  logic [11:0] x_o, y_o;

  int n_checks = 0;
  int n_fail   = 0;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .en_i(en_i), .pattern_i(pattern_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o),
    .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] out_vec();
    return {hsync_o, vsync_o, de_o, frame_start_o, x_o, y_o, rgb_o};
  endfunction

  // Reference pixel colour, computed directly from coordinates.
  function automatic logic [23:0] ref_pix(input logic [1:0] p, input int h, input int v);
    logic [11:0] hx, vy;
    hx = 12'(h);
    vy = 12'(v);
    case (p)
      2'd0: begin
        case (h / (HA / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd1: return ((h % 32 == 0) || (v % 32 == 0) || h == HA - 1 || v == VA - 1)
                   ? 24'hFFFFFF : 24'h000000;
      2'd2: return {hx[7:0], vy[7:0], hx[7:0] ^ vy[7:0]};
      default: return 24'h808080;
    endcase
  endfunction

  function automatic logic [51:0] ref_out(input int h, input int v, input logic [1:0] p,
                                          input logic [11:0] hx, input logic [11:0] hy);
    bit act, hs_on, vs_on;
    act   = (h < HA) && (v < VA);
    hs_on = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs_on = (v >= VA + VFP) && (v < VA + VFP + VSW);
    return {~hs_on, ~vs_on, act, (h == 0 && v == 0),
            act ? 12'(h) : hx, act ? 12'(v) : hy,
            act ? ref_pix(p, h, v) : 24'h0};
  endfunction

  // Scoreboard: model state and expected-output queue.
  logic [51:0] sb[$];
  int          mh, mv;
  logic [1:0]  mpat;
  logic [11:0] mx, my;

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sb.delete();
      if (clk) sb.push_back(RESET_VEC);
      mh <= 0; mv <= 0; mpat <= 2'd0; mx <= 12'd0; my <= 12'd0;
    end else if (!en_i) begin
      sb.push_back({1'b1, 1'b1, 1'b0, 1'b0, mx, my, 24'h0});
      mh <= 0; mv <= 0;
    end else begin
      sb.push_back(ref_out(mh, mv, (mh == 0 && mv == 0) ? pattern_i : mpat, mx, my));
      if (mh < HA && mv < VA) begin
        mx <= 12'(mh);
        my <= 12'(mv);
      end
      if (mh == 0 && mv == 0) mpat <= pattern_i;
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
    else chk("sb_out", out_vec(), sb.pop_front());
  end

  // Run-length and spacing measurements of the sync/enable waveforms.
  int cyc = 0, de_hi = 0, de_lo = 0, hs_lo = 0, vs_lo = 0, bursts = 0;
  int de_rise_cyc = 0, fs_cyc = 0;
  int m_de_hi = 0, m_de_lo = 0, m_hs_lo = 0, m_hs_off = 0;
  int m_vs_lo = 0, m_vs_off = 0, m_fs_per = 0, m_bursts = 0;
  bit fs_seen = 1'b0;
  logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    p_de  <= de_o; p_hs <= hsync_o; p_vs <= vsync_o;
    de_hi <= de_o ? de_hi + 1 : 0;
    de_lo <= de_o ? 0 : de_lo + 1;
    hs_lo <= hsync_o ? 0 : hs_lo + 1;
    vs_lo <= vsync_o ? 0 : vs_lo + 1;
    if (!de_o && p_de) m_de_hi <= de_hi;
    if (de_o && !p_de) begin
      m_de_lo     <= de_lo;
      de_rise_cyc <= cyc;
      bursts      <= frame_start_o ? 1 : bursts + 1;
    end
    if (hsync_o && !p_hs) m_hs_lo <= hs_lo;
    if (!hsync_o && p_hs) m_hs_off <= cyc - de_rise_cyc;
    if (vsync_o && !p_vs) m_vs_lo <= vs_lo;
    if (!vsync_o && p_vs) m_vs_off <= cyc - fs_cyc;
    if (frame_start_o) begin
      if (fs_seen) m_fs_per <= cyc - fs_cyc;
      fs_cyc   <= cyc;
      fs_seen  <= 1'b1;
      m_bursts <= bursts;
    end
  end

  task automatic wait_pix(input int x, input int y);
    int n = 0;
    bit found;
    do begin
      @(negedge clk);
      n++;
      found = de_o && (x_o == 12'(x)) && (y_o == 12'(y));
    end while (!found && n < 2 * FRAME + 10);
    chk($sformatf("reach_%0d_%0d", x, y), 64'(found), 64'd1);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start_o && n < FRAME + 10);
    chk("reach_frame_start", 64'(frame_start_o), 64'd1);
  endtask

  initial begin
    rstn_i = 1'b0; en_i = 1'b0; pattern_i = 2'd0;
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("reset_state", out_vec(), RESET_VEC);

    // Enable with colour bars.
    en_i = 1'b1;
    @(negedge clk);
    chk("first_de", de_o, 1'b1);
    chk("first_fs", frame_start_o, 1'b1);
    chk("first_xy", {x_o, y_o}, 24'd0);
    chk("bar_x0", rgb_o, 24'hFFFFFF);
    @(negedge clk);
    chk("fs_single", frame_start_o, 1'b0);
    wait_pix(HA / 8 - 1, 0); chk("bar_last_of_0", rgb_o, 24'hFFFFFF);
    wait_pix(HA / 8, 0);     chk("bar_first_of_1", rgb_o, 24'hFFFF00);
    wait_pix(HA / 2, 0);     chk("bar_mid", rgb_o, 24'hFF00FF);
    wait_pix(HA - 1, 0);     chk("bar_last", rgb_o, 24'h000000);

    // Switch to gradient mid-frame; bars must persist to end of frame.
    wait_pix(0, 20);
    pattern_i = 2'd2;
    chk("de_high_len", m_de_hi, HA);
    chk("de_low_len", m_de_lo, HT - HA);
    chk("hs_low_len", m_hs_lo, HSW);
    chk("hs_offset", m_hs_off, HA + HFP);
    wait_pix(HA / 8, 30);    chk("bars_persist", rgb_o, 24'hFFFF00);
    wait_fs();
    chk("grad_origin", rgb_o, 24'h000000);
    wait_pix(5, 3);          chk("grad_5_3", rgb_o, 24'h050306);
    chk("frame_period", m_fs_per, FRAME);
    chk("de_bursts", m_bursts, VA);
    chk("vs_low_len", m_vs_lo, VSW * HT);
    chk("vs_offset", m_vs_off, (VA + VFP) * HT);

    // Grid pattern.
    pattern_i = 2'd1;
    wait_fs();
    wait_pix(32, 7);         chk("grid_32_7", rgb_o, 24'hFFFFFF);
    wait_pix(33, 7);         chk("grid_33_7", rgb_o, 24'h000000);

    // Disable for 10 cycles mid-line.
    wait_pix(10, 5);
    en_i = 1'b0;
    @(negedge clk);
    chk("dis_outputs", {hsync_o, vsync_o, de_o, frame_start_o, rgb_o}, {4'b1100, 24'h0});
    chk("dis_xy_hold", {x_o, y_o}, {12'd10, 12'd5});
    repeat (9) @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
    chk("reen_fs", {frame_start_o, de_o, x_o, y_o}, {2'b11, 24'd0});

    // Asynchronous reset pulse between clock edges.
    wait_pix(20, 2);
    #2 rstn_i = 1'b0;
    #1 chk("async_reset", out_vec(), RESET_VEC);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
